// File: rtl/rsa_pkg.sv
// Shared types for the RSA exponentiation sequencer: controller states,
// multiplier operand selects, and the bit-index width helper.
package rsa_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_INIT     = 4'd1,
        ST_SQR_REQ  = 4'd2,
        ST_SQR_WAIT = 4'd3,
        ST_MUL_REQ  = 4'd4,
        ST_MUL_WAIT = 4'd5,
        ST_NEXT     = 4'd6,
        ST_OUT_REQ  = 4'd7,
        ST_OUT_WAIT = 4'd8,
        ST_STORE    = 4'd9,
        ST_DONE     = 4'd10
    } ctrl_state_e;

    typedef enum logic [1:0] {
        OP_SQR = 2'd0,
        OP_MUL = 2'd1,
        OP_OUT = 2'd2
    } op_sel_e;

    // Width of an index that addresses bits 0..w-1 (at least one bit).
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/rsa_bit_counter.sv
// Exponent bit-index down-counter: loads the MSB index at the start of a
// run, steps down once per processed bit, and flags when bit 0 is current.
module rsa_bit_counter
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             load,
    input  logic             dec,
    output logic [IDX_W-1:0] idx,
    output logic             zero
);

    // Index register; frozen while ena is low, load wins over dec.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            idx <= '0;
        end else if (ena) begin
            if (load) begin
                idx <= IDX_W'(WIDTH - 1);
            end else if (dec) begin
                idx <= idx - 1'b1;
            end
        end
    end

    assign zero = (idx == '0);

endmodule

// File: rtl/rsa_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for the RSA datapath. Issues
// multiply requests with operand selects to the shared Montgomery
// multiplier and strobes the working and ciphertext register loads.
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] exp_i,
    input  logic             mmul_done,
    output logic             mmul_start,
    output logic [1:0]       op_sel,
    output logic             init_sel,
    output logic             load_r,
    output logic             load_c,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = idx_width(WIDTH);

    ctrl_state_e      state;
    ctrl_state_e      state_nxt;
    logic [WIDTH-1:0] exp_q;
    logic [IDX_W-1:0] idx;
    logic             idx_zero;
    logic             cnt_load;
    logic             cnt_dec;
    logic             exp_bit;

    assign exp_bit = exp_q[idx];

    rsa_bit_counter #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_bit_counter (
        .clk  (clk),
        .rstb (rstb),
        .ena  (ena),
        .load (cnt_load),
        .dec  (cnt_dec),
        .idx  (idx),
        .zero (idx_zero)
    );

    // State register; holds while ena is low.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Exponent capture on an accepted start; stable for the rest of the run.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            exp_q <= '0;
        end else if (ena && (state == ST_IDLE) && start) begin
            exp_q <= exp_i;
        end
    end

    // Next-state and output decode; strobes are gated by ena, everything by reset.
    always_comb begin
        state_nxt  = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        mmul_start = 1'b0;
        op_sel     = OP_SQR;
        init_sel   = 1'b0;
        load_r     = 1'b0;
        load_c     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    cnt_load  = 1'b1;
                    state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                init_sel  = 1'b1;
                load_r    = 1'b1;
                state_nxt = ST_SQR_REQ;
            end
            ST_SQR_REQ: begin
                mmul_start = 1'b1;
                op_sel     = OP_SQR;
                state_nxt  = ST_SQR_WAIT;
            end
            ST_SQR_WAIT: begin
                op_sel = OP_SQR;
                if (mmul_done) begin
                    load_r    = 1'b1;
                    state_nxt = exp_bit ? ST_MUL_REQ : ST_NEXT;
                end
            end
            ST_MUL_REQ: begin
                mmul_start = 1'b1;
                op_sel     = OP_MUL;
                state_nxt  = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                op_sel = OP_MUL;
                if (mmul_done) begin
                    load_r    = 1'b1;
                    state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // Test for bit 0 before decrementing so the index never wraps.
                if (idx_zero) begin
                    state_nxt = ST_OUT_REQ;
                end else begin
                    cnt_dec   = 1'b1;
                    state_nxt = ST_SQR_REQ;
                end
            end
            ST_OUT_REQ: begin
                mmul_start = 1'b1;
                op_sel     = OP_OUT;
                state_nxt  = ST_OUT_WAIT;
            end
            ST_OUT_WAIT: begin
                op_sel = OP_OUT;
                if (mmul_done) begin
                    state_nxt = ST_STORE;
                end
            end
            ST_STORE: begin
                load_c    = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase

        if (!ena) begin
            mmul_start = 1'b0;
            load_r     = 1'b0;
            load_c     = 1'b0;
            done       = 1'b0;
        end

        if (!rstb) begin
            mmul_start = 1'b0;
            op_sel     = OP_SQR;
            init_sel   = 1'b0;
            load_r     = 1'b0;
            load_c     = 1'b0;
            busy       = 1'b0;
            done       = 1'b0;
        end
    end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Bench for rsa_exp_ctrl: a cycle-trace model derived from the
// square-and-multiply schedule, a latency-L multiplier with a plain modular
// datapath, and directed runs with hand-computed latencies and results.
module tb_rsa_exp_ctrl;

    localparam int W    = 4;
    localparam int MODN = 23;
    localparam int BASE = 5;

    localparam int PH_INIT     = 1;
    localparam int PH_REQ      = 2;
    localparam int PH_SQR_WAIT = 3;
    localparam int PH_MUL_WAIT = 4;
    localparam int PH_OUT_WAIT = 5;
    localparam int PH_NEXT     = 6;
    localparam int PH_STORE    = 7;
    localparam int PH_DONE     = 8;

    logic         clk = 1'b0;
    logic         rstb;
    logic         ena;
    logic         start;
    logic [W-1:0] exp_i;
    logic         mmul_done;
    logic         mmul_start;
    logic [1:0]   op_sel;
    logic         init_sel;
    logic         load_r;
    logic         load_c;
    logic         busy;
    logic         done;

    rsa_exp_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .ena        (ena),
        .start      (start),
        .exp_i      (exp_i),
        .mmul_done  (mmul_done),
        .mmul_start (mmul_start),
        .op_sel     (op_sel),
        .init_sel   (init_sel),
        .load_r     (load_r),
        .load_c     (load_c),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ph;
        logic       ms;
        logic [1:0] op;
        logic       chk_op;
        logic       lr;
        logic       lc;
        logic       is;
        logic       bz;
        logic       dn;
    } exp_t;

    exp_t q[$];
    int   op_log[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int c0 = 0;
    int mult_l = 3;
    int mcnt = 0;
    int r_reg = 0;
    int c_reg = 0;
    int mres = 0;
    int n_ms = 0;
    int n_lr = 0;
    int n_lc = 0;
    int n_dn = 0;

    logic         s_rstb = 1'b0;
    logic         s_ena = 1'b0;
    logic         s_start = 1'b0;
    logic [W-1:0] s_exp = '0;
    logic         s_ms = 1'b0;
    logic [1:0]   s_op = 2'd0;
    logic         s_lr = 1'b0;
    logic         s_lc = 1'b0;
    logic         s_is = 1'b0;
    logic         s_done = 1'b0;
    logic         mult_done = 1'b0;
    logic         spur = 1'b0;

    assign mmul_done = mult_done | spur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic chk_str(input string nm, input string act, input string req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", nm, act, req);
        end
    endtask

    function automatic int modexp(input int b, input int e, input int n);
        int r;
        r = 1;
        for (int k = 0; k < e; k++) r = (r * b) % n;
        return r;
    endfunction

    task automatic push(input int ph, input logic ms, input logic [1:0] op, input logic chk_op,
                        input logic lr, input logic lc, input logic is, input logic bz, input logic dn);
        exp_t e;
        e.ph = ph; e.ms = ms; e.op = op; e.chk_op = chk_op;
        e.lr = lr; e.lc = lc; e.is = is; e.bz = bz; e.dn = dn;
        q.push_back(e);
    endtask

    // One multiplier operation: request cycle then l wait cycles, result in the last.
    task automatic add_op(input logic [1:0] op, input int l, input logic wr, input int wph);
        push(PH_REQ, 1'b1, op, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= l; k++)
            push(wph, 1'b0, op, (op == 2'd0), (wr && (k == l)), 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Expected per-cycle outputs of a whole run, from the schedule alone.
    task automatic build_trace(input logic [W-1:0] e, input int l);
        push(PH_INIT, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = W - 1; i >= 0; i--) begin
            add_op(2'd0, l, 1'b1, PH_SQR_WAIT);
            if (e[i]) add_op(2'd1, l, 1'b1, PH_MUL_WAIT);
            push(PH_NEXT, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        add_op(2'd2, l, 1'b0, PH_OUT_WAIT);
        push(PH_STORE, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        push(PH_DONE, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Sample everything away from the active edge and compare against the trace.
    always @(negedge clk) begin
        exp_t e;
        s_rstb = rstb; s_ena = ena; s_start = start; s_exp = exp_i;
        s_ms = mmul_start; s_op = op_sel; s_lr = load_r; s_lc = load_c;
        s_is = init_sel; s_done = done;
        if (!rstb || q.size() == 0) begin
            chk("idle_outputs", 32'({mmul_start, op_sel, init_sel, load_r, load_c, busy, done}), 32'd0);
        end else begin
            e = q[0];
            if (!ena) begin
                chk("stall_outputs", 32'({mmul_start, load_r, load_c, done, busy}), 32'({4'b0000, e.bz}));
            end else begin
                chk("cycle_outputs", 32'({mmul_start, load_r, load_c, init_sel, busy, done}),
                    32'({e.ms, e.lr, e.lc, e.is, e.bz, e.dn}));
                if (e.chk_op) chk("op_sel", 32'(op_sel), 32'(e.op));
            end
        end
    end

    // Trace advance, latency-L multiplier and plain modular datapath.
    always @(posedge clk) begin
        cyc++;
        if (!s_rstb) begin
            q.delete();
            mcnt = 0;
        end else if (s_ena) begin
            if (q.size() == 0) begin
                if (s_start) begin
                    build_trace(s_exp, mult_l);
                    c0 = cyc;
                end
            end else begin
                void'(q.pop_front());
            end
            if (s_ms) begin
                mcnt = mult_l;
                n_ms++;
                op_log.push_back(int'(s_op));
                case (s_op)
                    2'd0:    mres = (r_reg * r_reg) % MODN;
                    2'd1:    mres = (r_reg * BASE) % MODN;
                    default: mres = r_reg % MODN;
                endcase
            end else if (mcnt > 0) begin
                mcnt--;
            end
            if (s_lr) begin
                n_lr++;
                r_reg = s_is ? 1 : mres;
            end
            if (s_lc) begin
                n_lc++;
                c_reg = mres;
            end
            if (s_done) n_dn++;
        end
        #1 mult_done = (mcnt == 1);
    end

    task automatic clear_counts();
        n_ms = 0; n_lr = 0; n_lc = 0; n_dn = 0;
        op_log.delete();
        c_reg = -1;
    endtask

    task automatic start_run(input logic [W-1:0] e, input int l);
        mult_l = l;
        clear_counts();
        start = 1'b1;
        exp_i = e;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_phase(input string nm, input int ph);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            if (q.size() > 0 && q[0].ph == ph) hit = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!hit) begin
            n_chk++; n_fail++;
            $display("FAIL %s_phase_timeout: phase %0d not reached, required within 200 cycles", nm, ph);
        end
    endtask

    task automatic finish_run(input string nm, input logic [W-1:0] e, input int lat, input int ms,
                              input int lr, input string ops, input int ct);
        bit    seen;
        string s;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: done not seen in 300 cycles, required at %0d", nm, lat);
        end else begin
            chk({nm, "_latency"}, 32'(cyc - c0), 32'(lat));
        end
        @(posedge clk); #1;
        s = "";
        foreach (op_log[i]) begin
            if (op_log[i] == 0)      s = {s, "S"};
            else if (op_log[i] == 1) s = {s, "M"};
            else                     s = {s, "O"};
        end
        chk_str({nm, "_ops"}, s, ops);
        chk({nm, "_mmul_starts"}, 32'(n_ms), 32'(ms));
        chk({nm, "_load_r"}, 32'(n_lr), 32'(lr));
        chk({nm, "_load_c"}, 32'(n_lc), 32'd1);
        chk({nm, "_done"}, 32'(n_dn), 32'd1);
        chk({nm, "_cipher"}, 32'(c_reg), 32'(ct));
        chk({nm, "_cipher_model"}, 32'(c_reg), 32'(modexp(BASE, int'(e), MODN)));
    endtask

    initial begin
        rstb = 1'b0; ena = 1'b1; start = 1'b0; exp_i = '0;
        repeat (3) @(posedge clk);
        #1 rstb = 1'b1;
        @(posedge clk); #1;

        // E = 1011, L = 3: 5^11 mod 23 = 22
        start_run(4'b1011, 3);
        finish_run("t1", 4'b1011, 38, 8, 8, "SMSSMSMO", 22);

        // E = 0, L = 1: squares only, result 1
        start_run(4'b0000, 1);
        finish_run("t2", 4'b0000, 16, 5, 5, "SSSSO", 1);

        // start with a different exponent mid-run is ignored
        start_run(4'b1011, 3);
        wait_phase("t3", PH_SQR_WAIT);
        start = 1'b1; exp_i = 4'b0100;
        @(posedge clk); #1;
        start = 1'b0;
        finish_run("t3", 4'b1011, 38, 8, 8, "SMSSMSMO", 22);

        // reset pulse during MUL_WAIT aborts the run
        start_run(4'b1011, 3);
        wait_phase("t4", PH_MUL_WAIT);
        rstb = 1'b0;
        @(posedge clk); #1;
        rstb = 1'b1;
        @(negedge clk);
        chk("t4_busy_after_reset", 32'(busy), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("t4_no_load_c", 32'(n_lc), 32'd0);
        chk("t4_no_done", 32'(n_dn), 32'd0);
        start_run(4'b1011, 3);
        finish_run("t4b", 4'b1011, 38, 8, 8, "SMSSMSMO", 22);

        // ena low for 5 cycles inside SQR_WAIT stretches latency by 5
        start_run(4'b1011, 3);
        wait_phase("t5", PH_SQR_WAIT);
        ena = 1'b0;
        repeat (5) @(posedge clk);
        #1 ena = 1'b1;
        finish_run("t5", 4'b1011, 43, 8, 8, "SMSSMSMO", 22);

        // spurious mmul_done in IDLE and in NEXT
        clear_counts();
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_idle_load_r", 32'(n_lr), 32'd0);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        start_run(4'b1011, 1);
        wait_phase("t6", PH_NEXT);
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        finish_run("t6", 4'b1011, 22, 8, 8, "SMSSMSMO", 22);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
